// File: rtl/flippy_pkg.sv
// Shared constants, lane record and LFSR step function for the Flippy Bit lane engine.
package flippy_pkg;

  localparam int ROWS   = 20;
  localparam int DATA_W = 8;
  localparam int YPOS_W = 5;

  // Galois feedback mask for taps 16,14,13,11 (shift right, xor on carry-out)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  LEVEL_MAX = 4'd15;

  typedef struct packed {
    logic              active;
    logic [YPOS_W-1:0] ypos;
    logic [DATA_W-1:0] letter;
  } lane_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/flippy_lfsr.sv
// 16-bit Galois LFSR that can move zero, one or two positions per clock.
module flippy_lfsr #(
  parameter logic [15:0] SEED  = 16'h00A5,
  parameter int          OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       advance,
  output logic [OUT_W-1:0] value
);
  import flippy_pkg::*;

  logic [15:0] state;
  logic [15:0] one_step;
  logic [15:0] two_step;

  always_comb begin
    one_step = lfsr_next(state);
    two_step = lfsr_next(one_step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else begin
      case (advance)
        2'd0:    state <= state;
        2'd1:    state <= one_step;
        default: state <= two_step;
      endcase
    end
  end

  assign value = state[OUT_W-1:0];

endmodule

// File: rtl/flippy_lane_engine.sv
// Falling-byte game engine: spawn, drop timing, fire matching, scoring, levels and game over.
module flippy_lane_engine #(
  parameter int          N_LANES   = 3,
  parameter int          DATA_W    = flippy_pkg::DATA_W,
  parameter int          ROWS      = flippy_pkg::ROWS,
  parameter int          YPOS_W    = flippy_pkg::YPOS_W,
  parameter int          SCORE_W   = 8,
  parameter int unsigned BASE_DIV  = 32'd50_000_000,
  parameter int unsigned DIV_DEC   = 32'd5_000_000,
  parameter int unsigned MIN_DIV   = 32'd10_000_000,
  parameter int          LEVEL_PTS = 8,
  parameter int          SPAWN_GAP = 4,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_signal,
  input  logic                        run,
  input  logic                        fire,
  input  logic [DATA_W-1:0]           sw,
  output logic [N_LANES*DATA_W-1:0]   letters,
  output logic [N_LANES*YPOS_W-1:0]   ypos,
  output logic [N_LANES-1:0]          active,
  output logic [SCORE_W-1:0]          score,
  output logic [3:0]                  level,
  output logic                        hit,
  output logic                        miss,
  output logic                        game_over
);
  import flippy_pkg::*;

  localparam logic [15:0]       GAP_MAX = 16'(SPAWN_GAP);
  localparam logic [YPOS_W-1:0] Y_TOP   = YPOS_W'(ROWS - 1);

  logic                      live;
  logic                      fire_ok;
  logic                      step;
  logic [31:0]               div_cnt;
  logic [31:0]               div_dec;
  logic [31:0]               cur_div;
  logic [15:0]               gap;
  logic [15:0]               gap_inc;
  logic [15:0]               gap_n;
  logic [N_LANES-1:0]        win_mask;
  logic                      win_found;
  logic [YPOS_W-1:0]         win_y;
  logic                      hit_now;
  logic                      miss_now;
  logic [N_LANES-1:0]        clear_mask;
  logic [SCORE_W-1:0]        score_inc;
  logic                      score_room;
  logic                      level_up;
  logic [N_LANES-1:0]        active_n;
  logic [N_LANES*YPOS_W-1:0] ypos_n;
  logic [N_LANES*DATA_W-1:0] letters_n;
  logic [N_LANES-1:0]        spawn_mask;
  logic                      free_found;
  logic                      over;
  logic [1:0]                lfsr_adv;
  logic [DATA_W-1:0]         lfsr_val;
  logic [DATA_W-1:0]         letter_new;

  flippy_lfsr #(
    .SEED  ({8'h00, SEED}),
    .OUT_W (DATA_W)
  ) u_lfsr (
    .clk     (CLOCK_50),
    .rst     (reset_signal),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  assign live    = run && !game_over;
  assign fire_ok = live && fire;

  // Step period shrinks with level but never below MIN_DIV; the compare avoids underflow
  always_comb begin
    div_dec = 32'(level) * DIV_DEC;
    if (div_dec + MIN_DIV >= BASE_DIV) cur_div = MIN_DIV;
    else                               cur_div = BASE_DIV - div_dec;
  end

  assign step = live && (div_cnt == cur_div - 32'd1);

  // Deepest matching lane wins; strict > keeps the lowest index on a tie
  always_comb begin
    win_mask  = '0;
    win_found = 1'b0;
    win_y     = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (active[i] && (letters[i*DATA_W +: DATA_W] == sw) &&
          (!win_found || (ypos[i*YPOS_W +: YPOS_W] > win_y))) begin
        win_found   = 1'b1;
        win_y       = ypos[i*YPOS_W +: YPOS_W];
        win_mask    = '0;
        win_mask[i] = 1'b1;
      end
    end
  end

  assign hit_now    = fire_ok && win_found;
  assign miss_now   = fire_ok && !win_found;
  assign clear_mask = hit_now ? win_mask : '0;
  assign score_inc  = score + SCORE_W'(1);
  assign score_room = (score != '1);
  assign level_up   = hit_now && score_room && (level != LEVEL_MAX) &&
                      ((32'(score_inc) % 32'(LEVEL_PTS)) == 32'd0);
  assign gap_inc    = (gap == GAP_MAX) ? gap : gap + 16'd1;
  assign letter_new = (lfsr_val == '0) ? DATA_W'(1) : lfsr_val;

  // Fire resolves first, then the step moves or spawns on the post-fire lane set
  always_comb begin
    active_n   = active & ~clear_mask;
    ypos_n     = ypos;
    letters_n  = letters;
    gap_n      = gap;
    spawn_mask = '0;
    free_found = 1'b0;
    over       = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (clear_mask[i]) ypos_n[i*YPOS_W +: YPOS_W] = '0;
      if (step && active_n[i] && (ypos[i*YPOS_W +: YPOS_W] == Y_TOP)) over = 1'b1;
    end
    if (step && !over) begin
      for (int i = 0; i < N_LANES; i++) begin
        if (active_n[i]) ypos_n[i*YPOS_W +: YPOS_W] = ypos[i*YPOS_W +: YPOS_W] + YPOS_W'(1);
      end
      gap_n = gap_inc;
      if (gap_inc == GAP_MAX) begin
        for (int i = 0; i < N_LANES; i++) begin
          if (!active_n[i] && !free_found) begin
            free_found    = 1'b1;
            spawn_mask[i] = 1'b1;
          end
        end
      end
      if (free_found) gap_n = '0;
    end
    for (int i = 0; i < N_LANES; i++) begin
      if (spawn_mask[i]) begin
        active_n[i]                   = 1'b1;
        ypos_n[i*YPOS_W +: YPOS_W]    = '0;
        letters_n[i*DATA_W +: DATA_W] = letter_new;
      end
    end
    lfsr_adv = {1'b0, fire_ok} + {1'b0, free_found};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset_signal) begin
      letters   <= '0;
      ypos      <= '0;
      active    <= '0;
      score     <= '0;
      level     <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
      div_cnt   <= '0;
      gap       <= GAP_MAX;
    end else begin
      letters   <= letters_n;
      ypos      <= ypos_n;
      active    <= active_n;
      hit       <= hit_now;
      miss      <= miss_now;
      game_over <= game_over | over;
      gap       <= gap_n;
      if (hit_now && score_room) score <= score_inc;
      if (level_up) level <= level + 4'd1;
      if (live) div_cnt <= (step || level_up) ? 32'd0 : div_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_flippy_lane_engine.sv
// Scoreboard bench for flippy_lane_engine: a behavioural model queues expected outputs per edge.
module tb_flippy_lane_engine;

  localparam int N    = 3;
  localparam int DW   = 2;
  localparam int RW   = 20;
  localparam int YW   = 5;
  localparam int SCW  = 3;
  localparam int BASE = 20;
  localparam int DEC  = 8;
  localparam int MINP = 6;
  localparam int LP   = 2;
  localparam int GAP  = 2;
  localparam int OW   = N*DW + N*YW + N + SCW + 4 + 3;
  localparam logic [SCW-1:0] SMAX = '1;

  logic          CLOCK_50 = 1'b0;
  logic          reset_signal;
  logic          run;
  logic          fire;
  logic [DW-1:0] sw;
  logic [N*DW-1:0] letters;
  logic [N*YW-1:0] ypos;
  logic [N-1:0]    active;
  logic [SCW-1:0]  score;
  logic [3:0]      level;
  logic            hit;
  logic            miss;
  logic            game_over;

  logic [OW-1:0] obs;
  logic [OW-1:0] exp_v;
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  logic [DW-1:0]  m_let [N];
  logic [YW-1:0]  m_y   [N];
  logic [N-1:0]   m_act;
  logic [SCW-1:0] m_score;
  logic [3:0]     m_level;
  logic           m_hit, m_miss, m_go;
  int             m_div, m_gap;
  logic [15:0]    m_lfsr;

  flippy_lane_engine #(
    .N_LANES(N), .DATA_W(DW), .ROWS(RW), .YPOS_W(YW), .SCORE_W(SCW),
    .BASE_DIV(BASE), .DIV_DEC(DEC), .MIN_DIV(MINP), .LEVEL_PTS(LP),
    .SPAWN_GAP(GAP), .SEED(8'hA5)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_signal(reset_signal), .run(run), .fire(fire), .sw(sw),
    .letters(letters), .ypos(ypos), .active(active), .score(score), .level(level),
    .hit(hit), .miss(miss), .game_over(game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign obs = {letters, ypos, active, score, level, hit, miss, game_over};

  function automatic logic [15:0] tb_lfsr(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic int cdm();
    int d;
    d = int'(m_level) * DEC;
    return (d + MINP >= BASE) ? MINP : BASE - d;
  endfunction

  function automatic logic [OW-1:0] pack_model();
    logic [N*DW-1:0] l;
    logic [N*YW-1:0] y;
    for (int i = 0; i < N; i++) begin
      l[i*DW +: DW] = m_let[i];
      y[i*YW +: YW] = m_y[i];
    end
    return {l, y, m_act, m_score, m_level, m_hit, m_miss, m_go};
  endfunction

  function automatic int pick_lane();
    int cand[$];
    for (int i = 0; i < N; i++) if (m_act[i]) cand.push_back(i);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  task automatic model_eval(input logic rs, input logic r, input logic f, input logic [DW-1:0] s);
    int win, sp;
    logic live, stp, n_hit, n_miss, lv_up, over, spawned;
    logic [DW-1:0] lb;
    if (rs) begin
      for (int i = 0; i < N; i++) begin m_let[i] = '0; m_y[i] = '0; end
      m_act = '0; m_score = '0; m_level = '0; m_hit = 1'b0; m_miss = 1'b0; m_go = 1'b0;
      m_div = 0; m_gap = GAP; m_lfsr = 16'h00A5;
    end else begin
      live = r && !m_go;
      stp  = live && (m_div == cdm() - 1);
      win  = -1;
      if (live && f)
        for (int i = 0; i < N; i++)
          if (m_act[i] && m_let[i] == s && (win < 0 || m_y[i] > m_y[win])) win = i;
      n_hit = live && f && (win >= 0);
      n_miss = live && f && (win < 0);
      lv_up = 1'b0;
      spawned = 1'b0;
      if (n_hit) begin
        m_act[win] = 1'b0;
        m_y[win] = '0;
        if (m_score != SMAX) begin
          m_score++;
          if ((int'(m_score) % LP == 0) && m_level != 4'd15) begin m_level++; lv_up = 1'b1; end
        end
      end
      lb = m_lfsr[DW-1:0];
      if (lb == '0) lb = DW'(1);
      if (stp) begin
        over = 1'b0;
        for (int i = 0; i < N; i++) if (m_act[i] && m_y[i] == RW - 1) over = 1'b1;
        if (over) m_go = 1'b1;
        else begin
          for (int i = 0; i < N; i++) if (m_act[i]) m_y[i]++;
          if (m_gap < GAP) m_gap++;
          if (m_gap == GAP) begin
            sp = -1;
            for (int i = 0; i < N; i++) if (!m_act[i] && sp < 0) sp = i;
            if (sp >= 0) begin
              m_act[sp] = 1'b1; m_y[sp] = '0; m_let[sp] = lb; m_gap = 0; spawned = 1'b1;
            end
          end
        end
      end
      if (live && f) m_lfsr = tb_lfsr(m_lfsr);
      if (spawned) m_lfsr = tb_lfsr(m_lfsr);
      if (live) m_div = (stp || lv_up) ? 0 : m_div + 1;
      m_hit = n_hit;
      m_miss = n_miss;
    end
    exp_q.push_back(pack_model());
  endtask

  task automatic drive(input logic rs, input logic r, input logic f, input logic [DW-1:0] s);
    reset_signal = rs; run = r; fire = f; sw = s;
    model_eval(rs, r, f, s);
    @(posedge CLOCK_50);
    #1;
    fire = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL reset_cycle got=%h want=%h", obs, exp_v); else passes++;
    end
    checks++;
    if (obs !== '0) $display("FAIL reset_zero got=%h want=0", obs); else passes++;
  endtask

  task automatic test_spawn();
    for (int c = 0; c < 65; c++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL spawn c=%0d got=%h want=%h", c, obs, exp_v); else passes++;
    end
    // steps at edges 20/40/60: lane0 spawns (letter 1), moves twice; lane1 spawns (letter 2)
    checks++;
    if (active !== 3'b011 || ypos[9:0] !== 10'd2 || letters[3:0] !== 4'b1001)
      $display("FAIL spawn_fixed got act=%b ypos=%h let=%h want act=011 ypos=002 let=9",
               active, ypos[9:0], letters[3:0]);
    else passes++;
  endtask

  task automatic test_fire_hit();
    int idx, budget, n;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(5, 1);
      budget = 0;
      while (budget < 40 && ((k % 2 == 1) ? (m_div != cdm() - 1) : (budget < n))) begin
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL fire_idle k=%0d got=%h want=%h", k, obs, exp_v); else passes++;
        budget++;
      end
      idx = pick_lane();
      if (idx >= 0) begin
        drive(1'b0, 1'b1, 1'b1, m_let[idx]);
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) $display("FAIL fire_edge k=%0d got=%h want=%h", k, obs, exp_v); else passes++;
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0) $display("FAIL fire_hit_pulse k=%0d got hit=%b miss=%b want 1/0", k, hit, miss);
        else passes++;
      end
    end
  endtask

  task automatic test_miss();
    drive(1'b0, 1'b1, 1'b1, '0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) $display("FAIL miss_edge got=%h want=%h", obs, exp_v); else passes++;
    checks++;
    if (miss !== 1'b1 || hit !== 1'b0) $display("FAIL miss_pulse got miss=%b hit=%b want 1/0", miss, hit);
    else passes++;
  endtask

  task automatic test_pause();
    logic [OW-1:0] snap;
    for (int c = 0; c < 100; c++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(1)), DW'($urandom));
      if (c == 0) snap = pack_model();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL pause c=%0d got=%h want=%h", c, obs, exp_v); else passes++;
    end
    checks++;
    if (obs !== snap) $display("FAIL pause_hold got=%h want=%h", obs, snap); else passes++;
  endtask

  task automatic test_level();
    int idx, extra;
    extra = 0;
    for (int c = 0; c < 800 && extra < 2; c++) begin
      idx = pick_lane();
      if (idx >= 0 && $urandom_range(1) == 1) begin
        if (m_score == SMAX) extra++;
        drive(1'b0, 1'b1, 1'b1, m_let[idx]);
      end else drive(1'b0, 1'b1, 1'b0, '0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL level c=%0d got=%h want=%h", c, obs, exp_v); else passes++;
    end
    checks++;
    if (score !== 3'd7 || level !== 4'd3) $display("FAIL level_sat got score=%0d level=%0d want 7/3", score, level);
    else passes++;
  endtask

  task automatic test_game_over();
    logic [OW-1:0] snap;
    logic top_seen;
    int c;
    c = 0;
    while (c < 3000 && game_over !== 1'b1) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL over_run c=%0d got=%h want=%h", c, obs, exp_v); else passes++;
      c++;
    end
    checks++;
    top_seen = 1'b0;
    for (int i = 0; i < N; i++) if (active[i] && ypos[i*YW +: YW] == 5'd19) top_seen = 1'b1;
    if (game_over !== 1'b1 || !top_seen) $display("FAIL over_reached got go=%b top=%b want 1/1", game_over, top_seen);
    else passes++;
    snap = pack_model();
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), DW'($urandom));
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL over_hold k=%0d got=%h want=%h", k, obs, exp_v); else passes++;
    end
    checks++;
    if (obs !== snap) $display("FAIL over_frozen got=%h want=%h", obs, snap); else passes++;
  endtask

  task automatic test_random();
    drive(1'b1, 1'b1, 1'b1, DW'($urandom));
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== '0) $display("FAIL reset_mid got=%h want=0", obs); else passes++;
    for (int c = 0; c < 500; c++) begin
      drive(1'($urandom_range(9) == 0), 1'($urandom_range(7) != 0), 1'($urandom_range(9) < 3), DW'($urandom));
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_v); else passes++;
    end
  endtask

  initial begin
    reset_signal = 1'b1; run = 1'b0; fire = 1'b0; sw = '0;
    test_reset();
    test_spawn();
    test_fire_hit();
    test_miss();
    test_pause();
    test_level();
    test_game_over();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
